// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ack handshake: accept in IDLE, WAIT_CYCLES+1 wait cycles, one-cycle RESP.
// Latency WAIT_CYCLES+2 cycles request-to-ack; inputs are ignored while busy, so the initiator must hold off until ack.
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [1 << DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] idx;
  logic [4:0]  shift;
  logic [31:0] lane_mask, cur_word, rd_lanes, wr_word;
  logic        bad, commit;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign cur_word = mem[idx];
  assign commit   = (state_q == WAIT) && (cnt_q == 4'd0);

  // Big-endian lanes: the lowest byte offset lives in the most significant bits.
  always_comb begin
    shift     = 5'd0;
    lane_mask = 32'h0;
    case (size_q)
      2'b00: lane_mask = 32'hFFFF_FFFF;
      2'b01: begin
        shift     = addr_q[1] ? 5'd0 : 5'd16;
        lane_mask = 32'h0000_FFFF << shift;
      end
      2'b10: begin
        shift     = {2'd3 - addr_q[1:0], 3'b000};
        lane_mask = 32'h0000_00FF << shift;
      end
      default: lane_mask = 32'h0;
    endcase
    bad = (size_q == 2'b11)
       || ((size_q == 2'b00) && (addr_q[1:0] != 2'b00))
       || ((size_q == 2'b01) && addr_q[0])
       || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
    rd_lanes = (cur_word & lane_mask) >> shift;
    wr_word  = (cur_word & ~lane_mask) | ((wdata_q << shift) & lane_mask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = bad;
          rdata_d = (bad || wr_q) ? 32'h0 : rd_lanes;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset so contents survive it; reset forces IDLE, which blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !bad) mem[idx] <= wr_word;
  end

  assign busy  = (state_q != IDLE);
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with WAIT_CYCLES=2, DEPTH_LOG2=8.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // One access; lat counts negedges after the accepting edge until ack (99 on timeout).
  task automatic do_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, output int lat,
                           output logic [31:0] rd, output logic e);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; wr = ~w; size = 2'b11; addr = 32'hFFFF_FFFF; wdata = ~d;
    lat = 0; rd = 32'h0; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (ack) begin
        rd = rdata; e = err;
        return;
      end
    end
    lat = 99;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (ack !== 1'b0)   begin n_bad++; $display("FAIL reset_ack got %b exp 0", ack); end
    n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    reset = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic e;
    do_access(1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF, lat, rd, e);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL word_wr_lat got %0d exp 4", lat); end
    n_cmp++; if (e !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL word_wr_resp got err=%b rd=%h exp err=0 rd=0", e, rd); end
    do_access(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL word_rd_lat got %0d exp 4", lat); end
    n_cmp++; if (e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_rd got err=%b rd=%h exp err=0 rd=deadbeef", e, rd); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic e;
    do_access(1'b1, 2'b10, 32'h11, 32'h0000_00AA, lat, rd, e);
    n_cmp++; if (lat !== 4 || e !== 1'b0) begin n_bad++; $display("FAIL byte_wr got lat=%0d err=%b exp lat=4 err=0", lat, e); end
    do_access(1'b0, 2'b10, 32'h11, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'h0000_00AA || e !== 1'b0) begin n_bad++; $display("FAIL byte_rd got rd=%h err=%b exp 000000aa err=0", rd, e); end
    do_access(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'hDEAA_BEEF) begin n_bad++; $display("FAIL byte_word_rd got %h exp deaabeef", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic e;
    do_access(1'b0, 2'b01, 32'h12, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'h0000_BEEF || e !== 1'b0) begin n_bad++; $display("FAIL half_rd got rd=%h err=%b exp 0000beef err=0", rd, e); end
    do_access(1'b0, 2'b01, 32'h13, 32'h0, lat, rd, e);
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 4) begin n_bad++; $display("FAIL half_misalign got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=4", e, rd, lat); end
    do_access(1'b1, 2'b01, 32'h13, 32'h0000_5555, lat, rd, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL half_misalign_wr got err=%b exp 1", e); end
    do_access(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'hDEAA_BEEF) begin n_bad++; $display("FAIL half_unchanged got %h exp deaabeef", rd); end
    do_access(1'b1, 2'b01, 32'h10, 32'h0000_1234, lat, rd, e);
    do_access(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'h1234_BEEF) begin n_bad++; $display("FAIL half_wr_hi got %h exp 1234beef", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e;
    do_access(1'b1, 2'b00, 32'h0, 32'h0102_0304, lat, rd, e);
    do_access(1'b1, 2'b00, 32'h400, 32'hFFFF_FFFF, lat, rd, e);
    n_cmp++; if (e !== 1'b1 || lat !== 4) begin n_bad++; $display("FAIL range_wr got err=%b lat=%0d exp err=1 lat=4", e, lat); end
    do_access(1'b0, 2'b00, 32'h0, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'h0102_0304) begin n_bad++; $display("FAIL range_unchanged got %h exp 01020304", rd); end
    do_access(1'b1, 2'b11, 32'h10, 32'hFFFF_FFFF, lat, rd, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL size11_wr got err=%b exp 1", e); end
    do_access(1'b0, 2'b11, 32'h10, 32'h0, lat, rd, e);
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL size11_rd got err=%b rd=%h exp err=1 rd=0", e, rd); end
    do_access(1'b0, 2'b00, 32'h12, 32'h0, lat, rd, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL word_misalign got err=%b exp 1", e); end
    do_access(1'b0, 2'b00, 32'h10, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'h1234_BEEF || e !== 1'b0) begin n_bad++; $display("FAIL size11_unchanged got rd=%h err=%b exp 1234beef err=0", rd, e); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic e; int acks;
    do_access(1'b1, 2'b00, 32'h20, 32'hCAFE_F00D, lat, rd, e);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_in_wait got busy=%b exp 1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || ack !== 1'b0) begin n_bad++; $display("FAIL abort_async got busy=%b ack=%b exp 0 0", busy, ack); end
    @(negedge clk);
    reset = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL abort_no_ack got %0d acks exp 0", acks); end
    do_access(1'b0, 2'b00, 32'h20, 32'h0, lat, rd, e);
    n_cmp++; if (rd !== 32'hCAFE_F00D || lat !== 4) begin n_bad++; $display("FAIL abort_retained got rd=%h lat=%0d exp cafef00d lat=4", rd, lat); end
  endtask

  task automatic test_first_after_reset();
    int lat; logic [31:0] rd; logic e;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_access(1'b0, 2'b00, 32'h0, 32'h0, lat, rd, e);
    n_cmp++; if (lat !== 4 || rd !== 32'h0102_0304) begin n_bad++; $display("FAIL post_reset_accept got lat=%0d rd=%h exp 4 01020304", lat, rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic e; logic exp_ack; logic [31:0] exp_rd;
    for (int k = 0; k < 11; k++)
      do_access(1'b1, 2'b00, 32'h30 + 32'(4 * k), 32'hA000_0000 + 32'(k), lat, rd, e);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_ack = (k == 4) || (k == 9) || (k == 14);
      exp_rd  = exp_ack ? 32'hA000_0000 + 32'(k - 4) : 32'h0;
      n_cmp++;
      if (ack !== exp_ack || rdata !== exp_rd) begin
        n_bad++;
        $display("FAIL b2b_k%0d got ack=%b rd=%h exp ack=%b rd=%h", k, ack, rdata, exp_ack, exp_rd);
      end
      req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h30 + 32'(4 * k);
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_abort();
    test_first_after_reset();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
